// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 access codes and FSM states.
package dmem_responder_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for RV32I loads/stores: store byte enables and lane-shifted
// write data, load lane extraction with sign/zero extension, and the misaligned/illegal flag.
module dmem_lane_align
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  we,
    input  logic [1:0]            addr_lo,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] word,
    output logic [3:0]            byte_en,
    output logic [DATA_WIDTH-1:0] wdata_lane,
    output logic [DATA_WIDTH-1:0] rdata_ext,
    output logic                  misalign
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte   = word[{addr_lo, 3'b000} +: 8];
        sel_half   = word[{addr_lo[1], 4'b0000} +: 16];
        byte_en    = '0;
        wdata_lane = '0;
        rdata_ext  = word;
        misalign   = 1'b0;

        // Replicated write data lets the byte enables alone pick the destination lane.
        case (funct3)
            F3_B: begin
                byte_en    = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            F3_H: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
            end
            F3_W: begin
                byte_en    = 4'b1111;
                wdata_lane = wdata;
            end
            default: ;
        endcase

        case (funct3)
            F3_B:    rdata_ext = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   rdata_ext = {24'd0, sel_byte};
            F3_H:    rdata_ext = {{16{sel_half[15]}}, sel_half};
            F3_HU:   rdata_ext = {16'd0, sel_half};
            default: rdata_ext = word;
        endcase

        if (we) begin
            case (funct3)
                F3_B:    misalign = 1'b0;
                F3_H:    misalign = addr_lo[0];
                F3_W:    misalign = (addr_lo != 2'b00);
                default: misalign = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_B, F3_BU: misalign = 1'b0;
                F3_H, F3_HU: misalign = addr_lo[0];
                F3_W:        misalign = (addr_lo != 2'b00);
                default:     misalign = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder with programmable wait states and an internal word RAM.
// Optional misalign/illegal-access error reporting is enabled by defining DMEM_MISALIGN_ERR_EN.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned BA = ADDR_WIDTH + 2;
    localparam logic [3:0]  LAST_CNT = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [BA-1:0]           addr_q, addr_d;
    logic [2:0]              f3_q, f3_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;

    logic [DATA_WIDTH-1:0]   ram [2**ADDR_WIDTH];

    logic                    idle, commit, ram_we;
    logic                    acc_we, acc_err, misalign;
    logic [BA-1:0]           acc_addr;
    logic [2:0]              acc_f3;
    logic [DATA_WIDTH-1:0]   acc_wdata, acc_word, wdata_lane, rdata_ext;
    logic [3:0]              byte_en;
    logic                    unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:BA];

    // With zero wait states the commit edge is the accept edge, so the live request is used.
    assign idle      = (state_q == IDLE);
    assign acc_we    = idle ? req_we              : we_q;
    assign acc_addr  = idle ? req_addr[BA-1:0]    : addr_q;
    assign acc_f3    = idle ? req_funct3          : f3_q;
    assign acc_wdata = idle ? req_wdata           : wdata_q;
    assign acc_word  = ram[acc_addr[BA-1:2]];

    dmem_lane_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .we         (acc_we),
        .addr_lo    (acc_addr[1:0]),
        .funct3     (acc_f3),
        .wdata      (acc_wdata),
        .word       (acc_word),
        .byte_en    (byte_en),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext),
        .misalign   (misalign)
    );

`ifdef DMEM_MISALIGN_ERR_EN
    assign acc_err = misalign;
`else
    logic unused_misalign;
    assign unused_misalign = misalign;
    assign acc_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = (WAIT_STATES == 0) ? RESP : WAIT;
            WAIT:    if (cnt_q == LAST_CNT) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = idle;
        commit    = (idle && req_valid && (WAIT_STATES == 0)) ||
                    ((state_q == WAIT) && (cnt_q == LAST_CNT));
        ram_we    = commit && acc_we && !acc_err;
    end

    always_comb begin
        we_d        = we_q;
        addr_d      = addr_q;
        f3_d        = f3_q;
        wdata_d     = wdata_q;
        cnt_d       = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (idle && req_valid) begin
            we_d    = req_we;
            addr_d  = req_addr[BA-1:0];
            f3_d    = req_funct3;
            wdata_d = req_wdata;
        end
        if ((state_q == WAIT) && (cnt_q != LAST_CNT)) cnt_d = cnt_q + 4'd1;
        if (commit) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = (acc_we || acc_err) ? '0 : rdata_ext;
            rsp_err_d   = acc_err;
        end else if ((state_q == RESP) && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            f3_q        <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            f3_q        <= f3_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byte_en[i]) ram[acc_addr[BA-1:2]][8*i +: 8] <= wdata_lane[8*i +: 8];
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: one responder with one wait state and one with none, checked against
// an arithmetic model of the byte-addressed memory.
module tb_dmem_responder;

    logic             clk;
    logic             rst;
    logic [1:0]       req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;
    logic [1:0][2:0]  req_funct3;

    logic [31:0] mdl [2][256];
    int          n_pass = 0;
    int          n_total = 0;

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_funct3(req_funct3[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_STATES(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_funct3(req_funct3[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    function automatic logic m_err(input logic we, input logic [31:0] a, input logic [2:0] f3);
`ifdef DMEM_MISALIGN_ERR_EN
        int unsigned off = a % 4;
        int unsigned c = f3;
        if (we && c > 2) return 1'b1;
        if (!we && (c == 3 || c > 5)) return 1'b1;
        if (c == 1 || c == 5) return (off % 2) != 0;
        if (c == 2) return off != 0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_op(input int d, input logic we, input logic [31:0] a, input logic [2:0] f3,
                            input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int unsigned idx = (a / 4) % 256;
        int unsigned bs  = (a % 4) * 8;
        int unsigned hs  = ((a % 4) / 2) * 16;
        logic [31:0] old = mdl[d][idx];
        logic [31:0] v;
        er = m_err(we, a, f3);
        rd = 32'd0;
        if (we) begin
            if (!er) begin
                case (f3)
                    3'd0: mdl[d][idx] = (old & ~(32'hFF << bs)) | ((wd % 256) << bs);
                    3'd1: mdl[d][idx] = (old & ~(32'hFFFF << hs)) | ((wd % 65536) << hs);
                    3'd2: mdl[d][idx] = wd;
                    default: ;
                endcase
            end
        end else if (!er) begin
            case (f3)
                3'd0: begin v = (old >> bs) % 256;   rd = (v >= 128)   ? v + 32'hFFFFFF00 : v; end
                3'd4: rd = (old >> bs) % 256;
                3'd1: begin v = (old >> hs) % 65536; rd = (v >= 32768) ? v + 32'hFFFF0000 : v; end
                3'd5: rd = (old >> hs) % 65536;
                default: rd = old;
            endcase
        end
    endtask

    task automatic access(input int d, input logic we, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat);
        int n = 0;
        @(negedge clk);
        req_we[d] = we; req_addr[d] = a; req_funct3[d] = f3; req_wdata[d] = wd;
        req_valid[d] = 1'b1;
        while (req_ready[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_before_accept", {31'd0, req_ready[d]}, 32'd1);
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (rsp_valid[d] !== 1'b1 && lat < 50);
        rd = rsp_rdata[d];
        er = rsp_err[d];
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[d] = 1'b0;
    endtask

    task automatic op(input int d, input logic we, input logic [31:0] a, input logic [2:0] f3,
                      input logic [31:0] wd, input string tag, output logic [31:0] rd);
        logic [31:0] exp_rd;
        logic        er, exp_er;
        int          lat;
        access(d, we, a, f3, wd, rd, er, lat);
        model_op(d, we, a, f3, wd, exp_rd, exp_er);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, {31'd0, er}, {31'd0, exp_er});
        check({tag, "_latency"}, 32'(lat), 32'(d + 1));
    endtask

    initial begin
        logic [31:0] rd, exp_rd, held;
        logic        exp_er;
        int          n;

        rst = 1'b0;
        req_valid = '0; req_we = '0; req_addr = '0; req_funct3 = '0; req_wdata = '0;
        rsp_ready = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_req_ready", {31'd0, req_ready[d]}, 32'd1);
            check("reset_rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
            check("reset_rsp_rdata", rsp_rdata[d], 32'd0);
            check("reset_rsp_err", {31'd0, rsp_err[d]}, 32'd0);
        end

        // Store then load a full word with one wait state.
        op(1, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, "sw_10", rd);
        check("sw_10_rdata_zero", rd, 32'd0);
        op(1, 1'b0, 32'h10, 3'd2, 32'd0, "lw_10", rd);
        check("lw_10_value", rd, 32'hDEADBEEF);

        // Byte and half lanes.
        op(1, 1'b1, 32'h10, 3'd2, 32'h11223344, "sw_base", rd);
        op(1, 1'b1, 32'h11, 3'd0, 32'h00000080, "sb_11", rd);
        op(1, 1'b0, 32'h10, 3'd2, 32'd0, "lw_after_sb", rd);
        check("sb_word", rd, 32'h11228044);
        op(1, 1'b0, 32'h11, 3'd0, 32'd0, "lb_11", rd);
        check("lb_11_value", rd, 32'hFFFFFF80);
        op(1, 1'b0, 32'h11, 3'd4, 32'd0, "lbu_11", rd);
        check("lbu_11_value", rd, 32'h00000080);
        op(1, 1'b0, 32'h12, 3'd1, 32'd0, "lh_12", rd);
        check("lh_12_value", rd, 32'h00001122);
        op(1, 1'b0, 32'h12, 3'd5, 32'd0, "lhu_12", rd);
        check("lhu_12_value", rd, 32'h00001122);

        // Back-pressure: response held for five cycles.
        @(negedge clk);
        req_we[1] = 1'b0; req_addr[1] = 32'h10; req_funct3[1] = 3'd2; req_valid[1] = 1'b1;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rsp_valid[1] !== 1'b1 && n < 50);
        model_op(1, 1'b0, 32'h10, 3'd2, 32'd0, exp_rd, exp_er);
        held = rsp_rdata[1];
        check("bp_rdata", held, exp_rd);
        repeat (5) begin
            @(negedge clk);
            check("bp_rsp_valid_hold", {31'd0, rsp_valid[1]}, 32'd1);
            check("bp_rsp_rdata_hold", rsp_rdata[1], exp_rd);
            check("bp_req_ready_low", {31'd0, req_ready[1]}, 32'd0);
        end
        rsp_ready[1] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[1] = 1'b0;
        @(negedge clk);
        check("bp_req_ready_back", {31'd0, req_ready[1]}, 32'd1);
        check("bp_rsp_valid_drop", {31'd0, rsp_valid[1]}, 32'd0);

        // Zero wait states and address aliasing.
        op(0, 1'b1, 32'h400, 3'd2, 32'hA5A5A5A5, "ws0_sw_400", rd);
        op(0, 1'b0, 32'h000, 3'd2, 32'd0, "ws0_lw_000", rd);
        check("ws0_alias_value", rd, 32'hA5A5A5A5);

        // Misaligned store: error with the flag, whole-word write without it.
        op(1, 1'b1, 32'h13, 3'd2, 32'hCAFEF00D, "sw_13", rd);
        op(1, 1'b0, 32'h10, 3'd2, 32'd0, "lw_after_sw_13", rd);
`ifdef DMEM_MISALIGN_ERR_EN
        check("sw_13_word_unchanged", rd, 32'h11228044);
`else
        check("sw_13_word_written", rd, 32'hCAFEF00D);
`endif

        // Reset during the wait state of a store discards it.
        op(1, 1'b1, 32'h20, 3'd2, 32'h12345678, "sw_20_old", rd);
        @(negedge clk);
        req_we[1] = 1'b1; req_addr[1] = 32'h20; req_funct3[1] = 3'd2;
        req_wdata[1] = 32'hFFFFFFFF; req_valid[1] = 1'b1;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        rst = 1'b0;
        #2;
        check("abort_rsp_valid", {31'd0, rsp_valid[1]}, 32'd0);
        check("abort_req_ready", {31'd0, req_ready[1]}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        op(1, 1'b0, 32'h20, 3'd2, 32'd0, "lw_20_after_abort", rd);
        check("abort_word_kept", rd, 32'h12345678);

        // Randomized mix over a small, fully initialised window with aliased addresses.
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 8; w++)
                op(d, 1'b1, 32'(w * 4 + 1024 * $urandom_range(0, 3)), 3'd2, $urandom, "rnd_init", rd);
            for (int k = 0; k < 40; k++)
                op(d, 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3) + 1024 * $urandom_range(0, 3)),
                   3'($urandom_range(0, 7)), $urandom, "rnd", rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
